// File: rtl/decode_stage.sv
// decode_stage: instruction decode, 32x32 register file, load-use hazard detect.
// Latency: all outputs combinational (zero cycles into ID/EX); register writes land at the rising edge.
// Backpressure: raises stall for one cycle on a load-use hazard and emits a bubble; write-back is never blocked.
//
// Ports:
//   clock, reset              pipeline clock; synchronous active-low reset
//   instr, instr_valid        instruction from IF/ID and its valid flag
//   wb_en, wb_addr, wb_data   register-file write-back port
//   ex_mem_read, ex_rd        load flag and destination of the instruction in EX
//   controller_IF, rd         control word and destination index to ID/EX
//   data_out1, data_out2      rs / rt register values
//   opcode_if, func_if, shamt, immediate_if, address_if   raw instruction fields
//   stall, illegal            hazard hold request; unsupported opcode flag
// Optional feature macro: WB_BYPASS_EN (write-back data forwarded to same-cycle reads).
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  output logic [7:0]  controller_IF,
  output logic [5:0]  opcode_if,
  output logic [5:0]  func_if,
  output logic [4:0]  shamt,
  output logic [4:0]  rd,
  output logic [31:0] data_out1,
  output logic [31:0] data_out2,
  output logic [15:0] immediate_if,
  output logic [25:0] address_if,
  output logic        stall,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [4:0] rs_idx;
  logic [4:0] rt_idx;

  assign opcode_if    = instr[31:26];
  assign func_if      = instr[5:0];
  assign shamt        = instr[10:6];
  assign immediate_if = instr[15:0];
  assign address_if   = instr[25:0];
  assign rs_idx       = instr[25:21];
  assign rt_idx       = instr[20:16];

  // Register file: entry 0 is hardwired to zero, so only 1..31 are stored.
  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];

  always_comb begin
    regs_d = regs_q;
    if (!reset) begin
      // Reset wins over a concurrent write-back.
      for (int i = 1; i < 32; i++) begin
        regs_d[i] = '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clock) begin
    regs_q <= regs_d;
  end

  logic [31:0] stored1;
  logic [31:0] stored2;

  assign stored1 = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
  assign stored2 = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];

`ifdef WB_BYPASS_EN
  // Forward only when the write will actually land this edge (not under reset).
  logic wb_live;
  assign wb_live   = reset && wb_en && (wb_addr != 5'd0);
  assign data_out1 = (wb_live && (wb_addr == rs_idx)) ? wb_data : stored1;
  assign data_out2 = (wb_live && (wb_addr == rt_idx)) ? wb_data : stored2;
`else
  assign data_out1 = stored1;
  assign data_out2 = stored2;
`endif

  // Opcode decode before bubble masking.
  logic [7:0] ctrl_raw;
  logic [4:0] rd_raw;
  logic       uses_rt;
  logic       legal;

  always_comb begin
    ctrl_raw = 8'h00;
    rd_raw   = 5'd0;
    uses_rt  = 1'b0;
    legal    = 1'b1;
    unique case (opcode_if)
      OP_RTYPE: begin
        ctrl_raw = 8'h80;
        rd_raw   = instr[15:11];
        uses_rt  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl_raw = 8'h88;
        rd_raw   = rt_idx;
      end
      OP_LW: begin
        ctrl_raw = 8'hD8;
        rd_raw   = rt_idx;
      end
      OP_SW: begin
        ctrl_raw = 8'h28;
        uses_rt  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_raw = 8'h04;
        uses_rt  = 1'b1;
      end
      OP_J: begin
        ctrl_raw = 8'h02;
      end
      OP_JAL: begin
        ctrl_raw = 8'h83;
        rd_raw   = 5'd31;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Load-use hazard: the load in EX produces a register this instruction reads.
  // Gated by reset so the hold request drops immediately when reset asserts.
  assign stall = reset && instr_valid && ex_mem_read && (ex_rd != 5'd0) &&
                 ((ex_rd == rs_idx) || ((ex_rd == rt_idx) && uses_rt));

  logic bubble;
  assign bubble = !reset || !instr_valid || stall;

  assign controller_IF = bubble ? 8'h00 : ctrl_raw;
  assign rd            = bubble ? 5'd0  : rd_raw;
  assign illegal       = bubble ? 1'b0  : !legal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the 5-stage pipeline. Takes the instruction held in IF/ID, reads the 32×32 register file and generates the 8-bit control word. It writes the write-back result into the register file and detects load-use hazards. Its outputs drive the ID/EX pipeline register directly. On a hazard it inserts a bubble and freezes PC and IF/ID.

## Interface
- No parameters. Register count 32, data width 32 are fixed.
- clock  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- instr  in  32  instruction from IF/ID
- instr_valid  in  1  IF/ID holds a real instruction
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register index
- wb_data  in  32  write-back data
- ex_mem_read  in  1  controller_EX[6] of the instruction currently in EX
- ex_rd  in  5  exec_rd of the instruction currently in EX
- controller_IF  out  8  control word to ID/EX
- opcode_if  out  6  instr[31:26]
- func_if  out  6  instr[5:0]
- shamt  out  5  instr[10:6]
- rd  out  5  destination register index
- data_out1  out  32  value of register rs = instr[25:21]
- data_out2  out  32  value of register rt = instr[20:16]
- immediate_if  out  16  instr[15:0]
- address_if  out  26  instr[25:0]
- stall  out  1  hold PC and IF/ID this cycle
- illegal  out  1  opcode not in the supported set

## Operation
- Control word bits:
  - [7] reg_write
  - [6] mem_read
  - [5] mem_write
  - [4] mem_to_reg
  - [3] alu_src_imm
  - [2] branch
  - [1] jump
  - [0] link
- Decode by opcode:
  - 0x00 R-type: 0x80, rd = instr[15:11]
  - 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui: 0x88, rd = instr[20:16]
  - 0x23 lw: 0xD8, rd = rt
  - 0x2B sw: 0x28, rd = 0
  - 0x04 beq, 0x05 bne: 0x04, rd = 0
  - 0x02 j: 0x02, rd = 0
  - 0x03 jal: 0x83, rd = 31
  - Any other opcode: 0x00, rd = 0, illegal = 1
- Register file:
  - On a rising edge with reset = 1, wb_en = 1 and wb_addr ≠ 0, write reg[wb_addr] ← wb_data.
  - reg[0] always reads 0; writes to it are discarded.
- Reads are combinational from the current register contents, subject to the bypass in Configuration.
- Hazard: stall = instr_valid & ex_mem_read & (ex_rd ≠ 0) & (ex_rd == rs | (ex_rd == rt & uses_rt)).
  - uses_rt = 1 for R-type, sw, beq, bne; 0 otherwise.
- Bubble: when stall = 1, instr_valid = 0 or reset = 0, controller_IF = 0x00 and rd = 0. illegal is forced 0 under the same conditions.
- Field outputs (opcode_if, func_if, shamt, immediate_if, address_if) always reflect instr.

## Timing
- All outputs are combinational from instr, register state and hazard inputs. Zero latency into ID/EX; ID/EX captures them on the next edge.
- Register write takes effect at the rising edge. Without bypass, a read in the same cycle returns the old value.
- Reset: on a rising edge with reset = 0, all 31 writable registers clear to 0 and any concurrent write is ignored.
- Output values while reset = 0:
  - controller_IF = 0, rd = 0, stall = 0, illegal = 0
  - data_out1 and data_out2 show pre-reset contents until the reset edge, then 0
- Load-use stall lasts exactly one cycle. The bubble empties EX, so ex_mem_read falls and the held instruction decodes normally on the following cycle.
- Simultaneous stall and write-back: the write proceeds. Write-back is never blocked.
- Reset mid-stall: stall drops immediately and no register write occurs on that edge.

## Configuration
- WB_BYPASS_EN defined: when wb_en = 1, wb_addr ≠ 0 and wb_addr matches rs (or rt), data_out1 (or data_out2) returns wb_data in the same cycle. This write-through removes the WB→ID hazard.
- WB_BYPASS_EN undefined: reads return stored contents only. Software or upstream logic must leave a 1-cycle gap between write-back and a dependent decode.

## Test plan
- Reset, then write reg5 = 0x0000_00AA. Decode R-type add $3,$5,$0 (instr 0x00A0_1820) on the next cycle -> data_out1 = 0xAA, data_out2 = 0, rd = 3, controller_IF = 0x80.
- Write reg0 = 0xFFFF_FFFF, then decode an instruction with rs = 0 -> data_out1 = 0.
- ex_mem_read = 1, ex_rd = 4, decode add with rs = 4 -> stall = 1, controller_IF = 0x00, rd = 0. Drop ex_mem_read -> stall = 0, controller_IF = 0x80.
- ex_mem_read = 1, ex_rd = 4, decode addi with rt = 4, rs = 2 -> stall = 0 (rt not used as a source).
- Same-cycle wb_en = 1, wb_addr = 7, wb_data = 0x1234, decode with rs = 7 -> data_out1 = 0x1234 with WB_BYPASS_EN, old value (0) without it.
- Decode opcode 0x3F -> illegal = 1, controller_IF = 0x00. Decode jal -> controller_IF = 0x83, rd = 31.
- Assert reset = 0 for one edge after filling regs 1–31 -> all read 0. A write on that edge is ignored.
